// File: rtl/addsub_pkg.sv
// Shared definitions for the add/sub accumulate stage: the FSM state
// encoding, the default widths, and the signed limit helpers used when
// the accumulator clamps instead of wrapping.
package addsub_pkg;

   localparam int DEF_WIDTH = 4;
   localparam int DEF_CNT_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Largest signed value representable in w bits.
   function automatic int s_max(input int w);
      return (1 << (w - 1)) - 1;
   endfunction

   // Smallest signed value representable in w bits.
   function automatic int s_min(input int w);
      return -(1 << (w - 1));
   endfunction

endpackage

// File: rtl/addsub_ovf_core.sv
// Combinational signed add/sub with two's-complement overflow detection.
// The same core sits in the upstream add/sub unit, so the accumulator's
// wrap and overflow behaviour matches it bit-for-bit.
module addsub_ovf_core #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             op,
   output logic [WIDTH-1:0] result,
   output logic             ov
);

   logic [WIDTH:0] ext;

   // Sign-extended add/sub at WIDTH+1 bits, wrapped result is the low WIDTH bits.
   // The top two bits of the extended result disagree exactly when the operand
   // signs allow overflow and the wrapped sign differs from a.
   always_comb begin
      // NOTE: every output of a combinational block is assigned on every path,
      // otherwise synthesis infers a latch to hold the old value.
      if (op) begin
         ext = {a[WIDTH-1], a} - {b[WIDTH-1], b};
      end else begin
         ext = {a[WIDTH-1], a} + {b[WIDTH-1], b};
      end
      result = ext[WIDTH-1:0];
      ov     = ext[WIDTH] ^ ext[WIDTH-1];
   end

endmodule

// File: rtl/addsub_accumulator.sv
// Burst accumulator: adds or subtracts a stream of signed operands into a
// running accumulator with a sticky overflow flag and a saturating operand
// count, then presents the result on an output handshake.
// Optional feature: define ADDSUB_ACC_SATURATE_EN to clamp the accumulator
// to the signed limit on overflow instead of wrapping.
module addsub_accumulator
   import addsub_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_op,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_acc,
   output logic             out_ov,
   output logic [CNT_W-1:0] out_count
);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] acc;
   logic             ov;
   logic [CNT_W-1:0] count;

   logic             accept;
   logic [WIDTH-1:0] core_a;
   logic [WIDTH-1:0] core_res;
   logic             core_ov;
   logic [WIDTH-1:0] acc_nxt;

   assign accept = in_valid && in_ready;

   // The first operand of a burst starts from zero, later ones from the accumulator.
   assign core_a = (state == ST_IDLE) ? '0 : acc;

   addsub_ovf_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .a      (core_a),
      .b      (in_data),
      .op     (in_op),
      .result (core_res),
      .ov     (core_ov)
   );

`ifdef ADDSUB_ACC_SATURATE_EN
   localparam logic [WIDTH-1:0] ACC_MAX = WIDTH'(s_max(WIDTH));
   localparam logic [WIDTH-1:0] ACC_MIN = WIDTH'(s_min(WIDTH));

   // Clamp toward the true result: overflow from a non-negative a goes high, from a negative a goes low.
   always_comb begin
      acc_nxt = core_res;
      if (core_ov) begin
         acc_nxt = core_a[WIDTH-1] ? ACC_MIN : ACC_MAX;
      end
   end
`else
   // Without saturation the accumulator simply keeps the wrapped result.
   assign acc_nxt = core_res;
`endif

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples its inputs from before the edge, independent of statement order.
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: bursts run IDLE -> RUN -> DONE, a single-operand burst skips RUN.
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE, ST_RUN: begin
            if (accept) begin
               state_nxt = in_last ? ST_DONE : ST_RUN;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Handshake outputs depend on state only, so no in_* to out_* path exists.
   always_comb begin
      in_ready  = (state != ST_DONE);
      out_valid = (state == ST_DONE);
   end

   // Datapath registers: first accept of a burst overwrites, later accepts accumulate.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc   <= '0;
         ov    <= 1'b0;
         count <= '0;
      end else if (accept) begin
         acc <= acc_nxt;
         if (state == ST_IDLE) begin
            ov    <= core_ov;
            count <= CNT_W'(1);
         end else begin
            ov <= ov | core_ov;
            if (count != '1) begin
               count <= count + CNT_W'(1);
            end
         end
      end
   end

   assign out_acc   = acc;
   assign out_ov    = ov;
   assign out_count = count;

endmodule

// File: doc/addsub_accumulator.md
# addsub_accumulator

Sequential accumulate stage directly downstream of the 4-bit signed add/sub unit. It accepts a burst of signed operands over a valid/ready handshake and adds or subtracts each one into a running signed accumulator, using the same two's-complement overflow rules as the add/sub unit. At the end of the burst it presents the result, a sticky overflow flag and an operand count on an output handshake. It is the first stateful consumer of the arithmetic datapath.

## Interface
- WIDTH, 4: operand and accumulator width, signed two's complement.
- CNT_W, 8: width of the operand counter.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  operand present.
- in_ready  output  1  block can accept an operand.
- in_data  input  WIDTH  signed operand b.
- in_op  input  1  0: acc + b, 1: acc - b.
- in_last  input  1  marks the final operand of the burst.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- out_acc  output  WIDTH  signed accumulated result.
- out_ov  output  1  sticky overflow flag for the burst.
- out_count  output  CNT_W  number of operands accepted in the burst.

## Operation
- The FSM has three states: IDLE, RUN and DONE. Reset enters IDLE.
- **Input handshake:** an operand is accepted when in_valid && in_ready. in_ready = 1 in IDLE and RUN, and 0 in DONE.
- **IDLE:** on accept, the operation uses a = 0.
  - acc is set to the result, ov is set to that operation's overflow, and count = 1.
  - The next state is DONE if in_last, otherwise RUN.
- **RUN:** on accept, the operation uses a = acc.
  - ov |= that operation's overflow, and count increments.
  - On in_last, the next state is DONE. With no accept, all state holds.
- **DONE:** out_valid = 1 and out_acc, out_ov, out_count are stable.
  - On out_ready, the next state is IDLE. The registers keep their values until the next burst's first accept overwrites them.
- **Arithmetic:** the sum or difference is computed at WIDTH+1 bits and the low WIDTH bits are taken (wrap).
- **Overflow rules:**
  - op = 0: overflow when a and b have the same sign and the result's sign differs from a.
  - op = 1: overflow when a and b have different signs and the result's sign differs from a.
  - Example: 7 + 1 → -8, overflow. -8 - 1 → 7, overflow. -8 + 0 → -8, no overflow.
- **Counter:** count saturates at 2^CNT_W-1 and does not wrap. out_ov does not reflect counter saturation.
- out_* show the register values at all times; they are qualified by out_valid only.

## Timing
- **Reset values:** state = IDLE, acc = 0, ov = 0, count = 0, in_ready = 1, out_valid = 0.
- Reset has priority over every other event. Reset mid-burst or during DONE discards the result; the block returns to IDLE on the next edge.
- **Latency:** a last operand accepted at edge N gives out_valid = 1 after edge N and the final values visible in the same cycle.
- **Result handshake:** out_valid = 1 with out_ready = 1 at edge M means in_ready = 1 from edge M. The earliest next accept is at edge M+1, so there is one bubble per burst.
- **Single-operand burst:** in_last on the first operand goes IDLE → DONE in one edge.
- out_ready asserted while out_valid = 0 has no effect.
- in_valid asserted during DONE is held off by in_ready = 0. The upstream stage must hold its data stable until accepted.
- No combinational path from in_* to out_*. in_ready depends only on state.

## Configuration
- **ADDSUB_ACC_SATURATE_EN defined:** on an overflowing operation, acc is clamped to the signed limit in the direction of the true result.
  - The limits are 2^(WIDTH-1)-1 and -2^(WIDTH-1) (+7 and -8 for WIDTH = 4).
  - ov is still set, and accumulation continues from the clamped value.
- **Undefined:** acc wraps modulo 2^WIDTH and ov is set.

## Structure
- A shared package, addsub_pkg, holds:
  - the FSM state enum: ST_IDLE, ST_RUN, ST_DONE;
  - the default WIDTH and CNT_W constants;
  - the signed min/max limit functions used by the saturation path.
- One sub-module, addsub_ovf_core, holds the combinational path.
  - Inputs: a, b, op. Outputs: wrapped result and overflow, at width WIDTH.
  - The accumulator instantiates it, so the rules match the upstream add/sub unit bit-for-bit.
- FSM, registers, counter and saturation muxing live in the top module.

## Test plan
- **Reset:** rst held 2 cycles, then released → in_ready = 1, out_valid = 0, out_acc = 0, out_ov = 0, out_count = 0.
- **Basic burst:** ops (+3), (+2), (-1 via op = 1, b = 1), last → out_acc = 4, out_ov = 0, out_count = 3, out_valid on the cycle after the last accept.
- **Positive overflow:** ops +7, +1 (last).
  - Without macro: out_acc = -8, out_ov = 1.
  - With macro: out_acc = 7, out_ov = 1.
- **Sticky overflow and negative overflow:** ops -8, op = 1 b = 1, +3 (last).
  - Without macro: acc goes 7 → 10 wraps to -6; out_acc = -6, out_ov = 1.
  - With macro: acc -8 → 3 → -5... stated precisely, clamped to -8, then -8 + 3 = -5; out_acc = -5, out_ov = 1.
- **Backpressure:** hold out_ready = 0 for 5 cycles with in_valid = 1 → in_ready stays 0 and out_* stay stable. Then pulse out_ready → IDLE, and the next operand is accepted one cycle later with a = 0.
- **Reset mid-burst:** rst after 2 accepted operands → IDLE, acc = 0. A following single-operand burst (-3, last) → out_acc = -3, out_count = 1.
